echo_meter: RTL and testbench
=============================

# echo_meter

Echo-pulse measurement stage of the ultrasonic sensor path, sitting directly downstream of the sensor control FSM. While the FSM is in its measure phase, this block times the sensor's echo pulse in microseconds and converts it to centimetres. It returns the handshake pulses the FSM consumes: a read request when the echo ends, a done pulse when the distance is ready, and a timeout pulse that forces the FSM back to idle.

## Interface
- CLK_FREQ_HZ, 100_000_000, clk frequency; the microsecond tick period is CLK_FREQ_HZ/1_000_000 cycles, which must be an integer ≥ 2.
- TIMEOUT_US, 38000, maximum echo wait plus width in µs, must be < 65536.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_measure  in  1  level, high while the FSM is in its measure phase; enables capture.
- echo  in  1  raw sensor echo pin, asynchronous.
- o_read  out  1  one-cycle pulse on echo falling edge; drives the FSM read request.
- o_done  out  1  one-cycle pulse when o_dist_cm is updated; drives the FSM done input.
- o_timeout  out  1  one-cycle pulse on timeout; drives the FSM return-to-idle input.
- o_dist_cm  out  10  last valid distance in cm, held between measurements.
- o_echo_us  out  16  last valid echo width in µs.
- o_valid  out  1  high once any measurement has completed since reset.

## Operation
- Echo synchroniser: 2 flops, plus one delay flop for edge detection. rise = sync & ~dly; fall = ~sync & dly.
- µs prescaler: counts 0..CLK_FREQ_HZ/1e6−1 and emits a tick on wrap. It restarts at 0 on entry to WAIT_RISE and on the rising edge.
- us_cnt: 16-bit counter, increments on tick, saturates at 0xFFFF.
- State machine:
  - IDLE: on i_measure=1, clear us_cnt and go to WAIT_RISE.
  - WAIT_RISE: on rise, clear us_cnt and go to COUNT. On i_measure=0, go to IDLE.
  - COUNT: on fall, latch us_cnt into o_echo_us, pulse o_read and go to DIVIDE. On i_measure=0, go to IDLE.
  - DIVIDE: 16-cycle restoring division of o_echo_us by 58. Then load o_dist_cm with the quotient (10 LSBs, max 1129 truncated is not possible under the default TIMEOUT_US since 38000/58 = 655), pulse o_done, set o_valid and go to HOLD.
  - HOLD: wait for i_measure=0, then go to IDLE. This prevents re-arming inside the same FSM cycle.
- Only edges are counted. An echo already high when WAIT_RISE is entered is ignored until it falls and rises again.
- Timeout: us_cnt is not cleared between WAIT_RISE and COUNT for timeout purposes. A separate 16-bit total counter starts at WAIT_RISE entry. When total == TIMEOUT_US in WAIT_RISE or COUNT:
  - pulse o_timeout and go to HOLD;
  - o_dist_cm, o_echo_us and o_valid are unchanged.
- Abort: i_measure=0 in WAIT_RISE or COUNT returns to IDLE with no pulses and no output change. DIVIDE always runs to completion and ignores i_measure.
- Simultaneous events:
  - fall and timeout in the same cycle: fall wins.
  - i_measure=0 and fall in the same cycle: abort wins.
- Remainder is discarded (floor division).

## Timing
- Reset values:
  - outputs: o_read=0, o_done=0, o_timeout=0, o_dist_cm=0, o_echo_us=0, o_valid=0;
  - internal: state IDLE, counters 0.
- Reset mid-operation returns everything to reset values immediately, including a DIVIDE in progress.
- Pin-to-edge latency: 3 clk (sync 2 + delay 1).
- o_read is asserted the cycle after fall is detected.
- o_done is asserted exactly 17 cycles after o_read, with o_dist_cm and o_valid valid in that same cycle.
- All pulses are exactly one clk wide; at most one of o_read, o_done, o_timeout is high in any cycle.
- Width resolution is ±1 µs.

## Configuration
- ECHO_TIMEOUT_EN:
  - Defined: timeout counter and o_timeout behave as above.
  - Undefined: no total counter; o_timeout is tied 0, and WAIT_RISE/COUNT are left only via edge or abort. TIMEOUT_US is unused.

## Structure
- sonic_pkg holds:
  - the state enum (IDLE, WAIT_RISE, COUNT, DIVIDE, HOLD);
  - US_PER_CM = 58;
  - widths US_W = 16 and CM_W = 10.
- One sub-module, echo_div58: sequential restoring divider by the constant US_PER_CM.
  - start/busy/done handshake;
  - 16-bit dividend, 10-bit quotient, fixed 16-cycle latency.

## Test plan
- CLK_FREQ_HZ=100e6, i_measure=1, echo high 580 µs → o_read once, then o_done 17 cycles later, o_echo_us=580, o_dist_cm=10, o_valid=1.
- Echo 23200 µs → o_dist_cm=400. Echo 115 µs → o_dist_cm=1 (floor).
- ECHO_TIMEOUT_EN defined, no echo for 38 ms → single o_timeout pulse, outputs keep previous values, state HOLD until i_measure=0.
- i_measure dropped 200 µs into a 1000 µs echo → no o_read/o_done, outputs unchanged; the next armed 580 µs echo gives 10 cm.
- Echo already high when i_measure rises, then falls and rises for 290 µs → o_dist_cm=5.
- rst_n asserted 5 cycles into DIVIDE → all outputs 0 immediately, no o_done pulse after release.

Source files
------------

// File: rtl/sonic_pkg.sv
// sonic_pkg: shared state encoding and widths for the ultrasonic echo path
package sonic_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_RISE, COUNT, DIVIDE, HOLD} state_t;
  localparam int US_PER_CM = 58;
  localparam int US_W = 16;
  localparam int CM_W = 10;
endpackage

// File: rtl/echo_div58.sv
// echo_div58: 16-cycle restoring divider of an echo width by US_PER_CM
module echo_div58
  import sonic_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [US_W-1:0] dividend,
  output logic            busy,
  output logic            done,
  output logic [CM_W-1:0] quotient
);
  logic [US_W-1:0] quo;
  logic [5:0] rem;
  logic [3:0] cnt;
  logic [6:0] trial;
  logic ge;
  assign trial = {rem, quo[US_W-1]};
  assign ge = trial >= 7'(US_PER_CM);
  assign quotient = quo[CM_W-1:0];
  // one quotient bit per cycle, dividend shifted out MSB first as quotient shifts in
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      quo <= '0;
      rem <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quo <= dividend;
        rem <= '0;
        cnt <= '0;
        busy <= 1'b1;
      end else if (busy) begin
        rem <= ge ? 6'(trial - 7'(US_PER_CM)) : trial[5:0];
        quo <= {quo[US_W-2:0], ge};
        cnt <= cnt + 4'd1;
        busy <= cnt != 4'd15;
        done <= cnt == 4'd15;
      end
    end
endmodule

// File: rtl/echo_meter.sv
// echo_meter: times the sensor echo in us and converts it to cm (ECHO_TIMEOUT_EN adds the timeout)
module echo_meter
  import sonic_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TIMEOUT_US = 38000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_measure,
  input  logic            echo,
  output logic            o_read,
  output logic            o_done,
  output logic            o_timeout,
  output logic [CM_W-1:0] o_dist_cm,
  output logic [US_W-1:0] o_echo_us,
  output logic            o_valid
);
  localparam int DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int PW = $clog2(DIV);
  if (DIV < 2 || DIV * 1_000_000 != CLK_FREQ_HZ || TIMEOUT_US >= 65536)
    $error("echo_meter: unsupported CLK_FREQ_HZ or TIMEOUT_US");
  state_t state, nxt;
  logic s1, s2, dly, rise, fall;
  logic [PW-1:0] pre;
  logic [US_W-1:0] us_cnt, us_nxt;
  logic run, arm, tick, to_hit, latch, finish, expire;
  logic div_busy, div_done;
  logic [CM_W-1:0] quotient;
  assign rise = s2 & ~dly;
  assign fall = ~s2 & dly;
  assign run = state == WAIT_RISE || state == COUNT;
  assign arm = state == IDLE && i_measure;
  assign tick = run && pre == PW'(DIV - 1);
  assign us_nxt = (tick && us_cnt != '1) ? us_cnt + 1'b1 : us_cnt;
  // two-flop synchroniser plus a delay flop for edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, s2, dly} <= '0;
    else {s1, s2, dly} <= {echo, s1, s2};
`ifdef ECHO_TIMEOUT_EN
  logic [US_W-1:0] total;
  assign to_hit = run && total == US_W'(TIMEOUT_US);
  // total elapsed time since arming; deliberately not cleared on the rising edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) total <= '0;
    else if (arm) total <= '0;
    else if (tick && total != '1) total <= total + 1'b1;
`else
  assign to_hit = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next state: abort beats fall, fall beats timeout, timeout beats a late rise
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = i_measure ? WAIT_RISE : IDLE;
      WAIT_RISE: nxt = !i_measure ? IDLE : to_hit ? HOLD : rise ? COUNT : WAIT_RISE;
      COUNT:     nxt = !i_measure ? IDLE : fall ? DIVIDE : to_hit ? HOLD : COUNT;
      DIVIDE:    nxt = div_done ? HOLD : DIVIDE;
      HOLD:      nxt = i_measure ? HOLD : IDLE;
      default:   nxt = IDLE;
    endcase
  end
  // transition events that drive the registered pulses and output loads
  always_comb begin
    latch = state == COUNT && nxt == DIVIDE;
    finish = state == DIVIDE && div_done;
    expire = run && nxt == HOLD;
  end
  // prescaler restarts on arming and on the rising edge so the width is edge-aligned
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pre <= '0;
    else pre <= (!run || arm || tick || (state == WAIT_RISE && rise)) ? '0 : pre + 1'b1;
  // width counter, handshake pulses and held results; the latched width includes a tick landing on the fall
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      us_cnt <= '0;
      o_read <= 1'b0;
      o_done <= 1'b0;
      o_timeout <= 1'b0;
      o_echo_us <= '0;
      o_dist_cm <= '0;
      o_valid <= 1'b0;
    end else begin
      us_cnt <= (arm || (state == WAIT_RISE && nxt == COUNT)) ? '0 : us_nxt;
      o_read <= latch;
      o_done <= finish;
      o_timeout <= expire;
      if (latch) o_echo_us <= us_nxt;
      if (finish) begin
        o_dist_cm <= quotient;
        o_valid <= 1'b1;
      end
    end
  echo_div58 u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (latch && !div_busy),
    .dividend(us_nxt),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(quotient)
  );
endmodule

// File: tb/tb_echo_meter.sv
// tb_echo_meter: scoreboard bench for echo_meter (timeout scenario runs when ECHO_TIMEOUT_EN is defined)
module tb_echo_meter;
  localparam int CLK_HZ = 2_000_000;
  localparam int DIV = 2;
`ifdef ECHO_TIMEOUT_EN
  localparam int TO_US = 3000;
  localparam int LONG_US = 2900;
  localparam int LONG_CM = 50;
`else
  localparam int TO_US = 38000;
  localparam int LONG_US = 23200;
  localparam int LONG_CM = 400;
`endif
  logic clk = 1'b0, rst_n = 1'b0, i_measure = 1'b0, echo = 1'b0;
  logic o_read, o_done, o_timeout, o_valid;
  logic [9:0] o_dist_cm;
  logic [15:0] o_echo_us;
  typedef struct {
    logic [15:0] us;
    logic [9:0] cm;
  } exp_t;
  exp_t sb[$];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, read_cnt = 0, done_cnt = 0, to_cnt = 0, read_cyc = 0;
  logic p_read = 1'b0, p_done = 1'b0, p_to = 1'b0;

  echo_meter #(.CLK_FREQ_HZ(CLK_HZ), .TIMEOUT_US(TO_US)) dut (
    .clk(clk), .rst_n(rst_n), .i_measure(i_measure), .echo(echo),
    .o_read(o_read), .o_done(o_done), .o_timeout(o_timeout),
    .o_dist_cm(o_dist_cm), .o_echo_us(o_echo_us), .o_valid(o_valid)
  );

  always #5 clk = ~clk;

  // monitor: pulse accounting, latency and scoreboard pop on every o_done
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if ((o_read && (o_done || o_timeout)) || (o_done && o_timeout) || (o_read && p_read) || (o_done && p_done) || (o_timeout && p_to)) begin
      n_tests++; n_fail++;
      $display("FAIL pulse_shape read=%0b done=%0b timeout=%0b prev=%0b%0b%0b expected one-cycle exclusive pulses", o_read, o_done, o_timeout, p_read, p_done, p_to);
    end
    {p_read, p_done, p_to} = {o_read, o_done, o_timeout};
    if (o_read) begin read_cnt++; read_cyc = cyc; end
    if (o_timeout) to_cnt++;
    if (o_done) begin
      done_cnt++;
      n_tests++;
      if (cyc - read_cyc !== 17) begin
        n_fail++;
        $display("FAIL done_latency got %0d cycles expected 17", cyc - read_cyc);
      end
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done got us=%0d cm=%0d expected no o_done", o_echo_us, o_dist_cm);
      end else begin
        e = sb.pop_front();
        if (o_echo_us !== e.us || o_dist_cm !== e.cm || o_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL result got us=%0d cm=%0d valid=%0b expected us=%0d cm=%0d valid=1", o_echo_us, o_dist_cm, o_valid, e.us, e.cm);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_echo(input int us);
    echo = 1'b1;
    cycles(us * DIV);
    echo = 1'b0;
  endtask

  task automatic push(input int us, input int cm);
    exp_t e;
    e.us = 16'(us);
    e.cm = 10'(cm);
    sb.push_back(e);
  endtask

  task automatic wait_done(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk);
      ok = done_cnt > base;
    end
  endtask

  task automatic measure(input int us, input int cm, input string name);
    int br, bd;
    bit ok;
    push(us, cm);
    i_measure = 1'b1;
    cycles(4);
    br = read_cnt;
    bd = done_cnt;
    pulse_echo(us);
    wait_done(bd, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL %s_done_wait got no o_done expected one within 80 cycles", name); end
    n_tests++;
    if (read_cnt - br !== 1) begin n_fail++; $display("FAIL %s_read_count got %0d expected 1", name, read_cnt - br); end
    i_measure = 1'b0;
    cycles(4);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cycles(3);
    n_tests++;
    if ({o_read, o_done, o_timeout, o_valid} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags got %b expected 0000", {o_read, o_done, o_timeout, o_valid});
    end
    n_tests++;
    if (o_dist_cm !== 10'd0 || o_echo_us !== 16'd0) begin
      n_fail++; $display("FAIL reset_data got cm=%0d us=%0d expected 0 0", o_dist_cm, o_echo_us);
    end
    rst_n = 1'b1;
    cycles(3);
  endtask

  task automatic test_basic;
    measure(580, 10, "basic");
  endtask

  task automatic test_long;
    measure(LONG_US, LONG_CM, "long");
  endtask

  task automatic test_floor;
    measure(115, 1, "floor");
  endtask

`ifdef ECHO_TIMEOUT_EN
  task automatic test_timeout;
    int bt, br;
    bit ok;
    bt = to_cnt;
    br = read_cnt;
    i_measure = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < TO_US * DIV + 200 && !ok; i++) begin
      @(negedge clk);
      ok = to_cnt > bt;
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL timeout_wait got no o_timeout expected one"); end
    n_tests++;
    if (o_dist_cm !== 10'd1 || o_echo_us !== 16'd115 || o_valid !== 1'b1) begin
      n_fail++; $display("FAIL timeout_hold_outputs got cm=%0d us=%0d valid=%0b expected 1 115 1", o_dist_cm, o_echo_us, o_valid);
    end
    cycles(10);
    pulse_echo(100);
    cycles(40);
    n_tests++;
    if (to_cnt - bt !== 1 || read_cnt !== br) begin
      n_fail++; $display("FAIL timeout_hold got timeouts=%0d reads=%0d expected 1 0", to_cnt - bt, read_cnt - br);
    end
    i_measure = 1'b0;
    cycles(4);
  endtask
`else
  task automatic test_no_timeout;
    i_measure = 1'b1;
    cycles(500);
    i_measure = 1'b0;
    cycles(4);
    n_tests++;
    if (to_cnt !== 0) begin n_fail++; $display("FAIL no_timeout got %0d pulses expected 0", to_cnt); end
  endtask
`endif

  task automatic test_abort;
    int br, bd;
    br = read_cnt;
    bd = done_cnt;
    i_measure = 1'b1;
    cycles(4);
    echo = 1'b1;
    cycles(200 * DIV);
    i_measure = 1'b0;
    cycles(800 * DIV);
    echo = 1'b0;
    cycles(20);
    n_tests++;
    if (read_cnt !== br || done_cnt !== bd) begin
      n_fail++; $display("FAIL abort_pulses got reads=%0d dones=%0d expected 0 0", read_cnt - br, done_cnt - bd);
    end
    n_tests++;
    if (o_dist_cm !== 10'd1 || o_echo_us !== 16'd115) begin
      n_fail++; $display("FAIL abort_outputs got cm=%0d us=%0d expected 1 115", o_dist_cm, o_echo_us);
    end
    measure(580, 10, "rearm");
  endtask

  task automatic test_prehigh;
    int br, bd;
    bit ok;
    echo = 1'b1;
    cycles(6);
    br = read_cnt;
    bd = done_cnt;
    i_measure = 1'b1;
    cycles(20);
    echo = 1'b0;
    cycles(10);
    push(290, 5);
    pulse_echo(290);
    wait_done(bd, ok);
    n_tests++;
    if (!ok || read_cnt - br !== 1) begin
      n_fail++; $display("FAIL prehigh got done=%0b reads=%0d expected 1 1", ok, read_cnt - br);
    end
    i_measure = 1'b0;
    cycles(4);
  endtask

  task automatic test_reset_divide;
    int br, bd;
    bit ok;
    i_measure = 1'b1;
    cycles(4);
    br = read_cnt;
    pulse_echo(580);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = read_cnt > br;
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rstdiv_read got no o_read expected one"); end
    bd = done_cnt;
    cycles(5);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_read, o_done, o_timeout, o_valid, o_dist_cm, o_echo_us} !== '0) begin
      n_fail++; $display("FAIL rstdiv_outputs got valid=%0b cm=%0d us=%0d expected all 0", o_valid, o_dist_cm, o_echo_us);
    end
    cycles(2);
    rst_n = 1'b1;
    i_measure = 1'b0;
    cycles(40);
    n_tests++;
    if (done_cnt !== bd || o_valid !== 1'b0 || o_dist_cm !== 10'd0) begin
      n_fail++; $display("FAIL rstdiv_after got dones=%0d valid=%0b cm=%0d expected 0 0 0", done_cnt - bd, o_valid, o_dist_cm);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_long();
    test_floor();
`ifdef ECHO_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_abort();
    test_prehigh();
    test_reset_divide();
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
